icache_responder: RTL



---
 rtl/lc3b_types.sv | 20 ++
 rtl/icache_array.sv | 46 ++++
 rtl/icache_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the instruction-cache additions (FSM state
// encoding, line offset width and a line-alignment helper).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  typedef enum logic {
    s_check = 1'b0,
    s_fill  = 1'b1
  } lc3b_icache_state;

  localparam int ICACHE_OFFSET_BITS = 4;

  // Clears the byte offset so the address names a whole 16-byte line.
  function automatic lc3b_word icache_line_align(input lc3b_word addr);
    return {addr[15:ICACHE_OFFSET_BITS], {ICACHE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: NUM_SETS entries of {valid, tag, 128-bit data}
// with an asynchronous read port, a synchronous write port and a valid clear on rst.
module icache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output lc3b_data         rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  lc3b_data         wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  lc3b_data            data_q [NUM_SETS];

  // Reset only invalidates; stale tag/data behind a cleared valid bit is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache with zero-wait hits and a
// CHECK/FILL miss engine. Optional hit/miss counters: ICACHE_PERF_COUNTERS_EN.
module icache_responder
  import lc3b_types::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  lc3b_word    imem_address,
  input  logic        imem_action_stb,
  input  logic        imem_action_cyc,
  output lc3b_data    imem_rdata,
  output logic        imem_resp,
  output lc3b_word    pmem_address,
  output logic        pmem_read,
  input  lc3b_data    pmem_rdata,
  input  logic        pmem_resp
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - OFFSET_BITS - IDX_W;

  // Handshake: a fetch request exists only while stb and cyc are both high.
  // imem_resp is combinational and valid for that same cycle only; the fetch
  // stage holds the request until it sees imem_resp. pmem_read stays high with
  // a stable pmem_address until the cycle pmem_resp is sampled high.

  lc3b_icache_state state_q;
  lc3b_word         miss_addr_q;
  logic             pmem_read_q;

  logic             req;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  lc3b_data         rd_data;
  logic             hit;
  logic             miss_start;
  logic             fill_we;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             unused_offset_bits;

  assign req     = imem_action_stb & imem_action_cyc;
  assign req_idx = imem_address[OFFSET_BITS +: IDX_W];
  assign req_tag = imem_address[15 -: TAG_W];

  assign fill_idx = miss_addr_q[OFFSET_BITS +: IDX_W];
  assign fill_tag = miss_addr_q[15 -: TAG_W];

  assign unused_offset_bits = ^{imem_address[OFFSET_BITS-1:0], miss_addr_q[OFFSET_BITS-1:0]};

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_we),
    .wr_idx_i   (fill_idx),
    .wr_tag_i   (fill_tag),
    .wr_data_i  (pmem_rdata)
  );

  assign hit        = (state_q == s_check) & req & rd_valid & (rd_tag == req_tag);
  assign miss_start = (state_q == s_check) & req & ~hit;
  // A response arriving while in CHECK belongs to a fill aborted by reset.
  assign fill_we    = (state_q == s_fill) & pmem_resp;

  assign imem_resp    = hit;
  assign imem_rdata   = rd_data;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = miss_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= s_check;
      miss_addr_q <= '0;
      pmem_read_q <= 1'b0;
    end else begin
      case (state_q)
        s_check: begin
          if (miss_start) begin
            miss_addr_q <= icache_line_align(imem_address);
            pmem_read_q <= 1'b1;
            state_q     <= s_fill;
          end
        end
        s_fill: begin
          if (pmem_resp) begin
            pmem_read_q <= 1'b0;
            state_q     <= s_check;
          end
        end
        default: begin
          pmem_read_q <= 1'b0;
          state_q     <= s_check;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (miss_start && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
